// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
//
// Pipelined-datapath register file with NUM_READ combinational read ports and
// two write ports (A: ALU writeback, B: load writeback). Reads see same-cycle
// writes through a bypass, with port B taking priority over port A. A pending
// bit per stored register tracks outstanding loads. After reset, a sequencer
// zeroes every stored register, one register per cycle.
//
// The PC slot (PC_INDEX) has no storage. Reads of it return pc_value, and
// writes and pend_set aimed at it are dropped.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   ready          high once the clear sequence has completed (registered)
//   read_addr      packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data      packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_pending   per read port: addressed register awaits a load
//   write_enable_a / write_addr_a / write_data_a   ALU writeback port
//   write_enable_b / write_addr_b / write_data_b   load writeback port
//   pend_set / pend_addr                           mark register as load target
//   pc_value       value returned for reads of PC_INDEX
// -----------------------------------------------------------------------------
module multiport_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_READ   = 3,
    parameter int PC_INDEX   = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           ready,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_pending,
    input  logic                           write_enable_a,
    input  logic [ADDR_WIDTH-1:0]          write_addr_a,
    input  logic [DATA_WIDTH-1:0]          write_data_a,
    input  logic                           write_enable_b,
    input  logic [ADDR_WIDTH-1:0]          write_addr_b,
    input  logic [DATA_WIDTH-1:0]          write_data_b,
    input  logic                           pend_set,
    input  logic [ADDR_WIDTH-1:0]          pend_addr,
    input  logic [DATA_WIDTH-1:0]          pc_value
);

    localparam logic [ADDR_WIDTH-1:0] PC_ADDR   = ADDR_WIDTH'(PC_INDEX);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  clr_idx_r;
    logic [NUM_REGS-1:0]    pending_r;
    logic                   ready_r;
    logic [DATA_WIDTH-1:0]  regs_r [NUM_REGS];

    logic [NUM_REGS-1:0]            pend_clr_s;
    logic [NUM_REGS-1:0]            pend_set_s;
    logic [NUM_REGS-1:0]            pending_next_s;
    logic [NUM_READ*DATA_WIDTH-1:0] read_data_s;
    logic [NUM_READ-1:0]            read_pending_s;
    logic                           wr_a_ok_s;
    logic                           wr_b_ok_s;
    logic                           pend_ok_s;

    // True for addresses that have storage (in range and not the PC slot).
    function automatic logic is_storable(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) < NUM_REGS) && (addr != PC_ADDR);
    endfunction

    // One-hot mask over the stored registers for a given address.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] addr);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction

    assign wr_a_ok_s = write_enable_a && is_storable(write_addr_a);
    assign wr_b_ok_s = write_enable_b && is_storable(write_addr_b);
    assign pend_ok_s = pend_set && is_storable(pend_addr);

    // Next pending vector: a load return clears its bit; a same-edge set on the same register wins.
    always_comb begin
        pend_clr_s     = wr_b_ok_s ? onehot(write_addr_b) : {NUM_REGS{1'b0}};
        pend_set_s     = pend_ok_s ? onehot(pend_addr)    : {NUM_REGS{1'b0}};
        pending_next_s = (pending_r & ~pend_clr_s) | pend_set_s;
    end

    // Clear sequencer, pending scoreboard and ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {ADDR_WIDTH{1'b0}};
            pending_r <= {NUM_REGS{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + ADDR_ONE;
                    if (clr_idx_r == LAST_ADDR) begin
                        state_r <= ST_RUN;
                        ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pending_r <= pending_next_s;
                    ready_r   <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_idx_r <= {ADDR_WIDTH{1'b0}};
                    pending_r <= {NUM_REGS{1'b0}};
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zeroed by the sequencer in CLEAR; written by ports A then B in RUN.
    // Port B is assigned last so that it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                if (is_storable(clr_idx_r)) begin
                    regs_r[clr_idx_r] <= {DATA_WIDTH{1'b0}};
                end
            end else begin
                if (wr_a_ok_s) begin
                    regs_r[write_addr_a] <= write_data_a;
                end
                if (wr_b_ok_s) begin
                    regs_r[write_addr_b] <= write_data_b;
                end
            end
        end
    end

    // Read ports: PC slot first, then clear masking, range check, bypass, storage.
    always_comb begin
        read_data_s    = {(NUM_READ*DATA_WIDTH){1'b0}};
        read_pending_s = {NUM_READ{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            logic [ADDR_WIDTH-1:0] addr_s;
            addr_s = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (addr_s == PC_ADDR) begin
                read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = pc_value;
                read_pending_s[i]                       = 1'b0;
            end else if (state_r != ST_RUN || !is_storable(addr_s)) begin
                read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                read_pending_s[i]                       = 1'b0;
            end else begin
                read_pending_s[i] = pending_r[addr_s];
                if (write_enable_b && write_addr_b == addr_s) begin
                    read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = write_data_b;
                end else if (write_enable_a && write_addr_a == addr_s) begin
                    read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = write_data_a;
                end else begin
                    read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[addr_s];
                end
            end
        end
    end

    assign read_data    = read_data_s;
    assign read_pending = read_pending_s;
    assign ready        = ready_r;

endmodule

// File: tb/tb_multiport_register_file.sv
// -----------------------------------------------------------------------------
// Testbench for multiport_register_file (default parameters).
// The driver applies one cycle of stimulus just after each rising edge. It
// derives the expected outputs for that cycle from a behavioural model and
// queues them. The monitor pops the queued values and compares them on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_multiport_register_file;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NREG = 16;
    localparam logic [AW-1:0] PC = 4'd15;

    logic             clk = 1'b0;
    logic             reset;
    logic             ready;
    logic [NR*AW-1:0] read_addr;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0]    read_pending;
    logic             write_enable_a, write_enable_b, pend_set;
    logic [AW-1:0]    write_addr_a, write_addr_b, pend_addr;
    logic [DW-1:0]    write_data_a, write_data_b, pc_value;

    multiport_register_file dut (
        .clk(clk), .reset(reset), .ready(ready),
        .read_addr(read_addr), .read_data(read_data), .read_pending(read_pending),
        .write_enable_a(write_enable_a), .write_addr_a(write_addr_a), .write_data_a(write_data_a),
        .write_enable_b(write_enable_b), .write_addr_b(write_addr_b), .write_data_b(write_data_b),
        .pend_set(pend_set), .pend_addr(pend_addr), .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rp;
        logic             rdy;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural contents, pending flags, and cycles since reset.
    logic [DW-1:0] m_mem  [NREG];
    logic          m_pend [NREG];
    bit            m_run;
    int            m_cnt;

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
        m_run = 1'b0;
        m_cnt = 0;
    endtask

    task automatic idle();
        write_enable_a = 1'b0;
        write_enable_b = 1'b0;
        pend_set       = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        read_addr = {a2, a1, a0};
    endtask

    // Queue this cycle's expected outputs, advance the model over the edge, then wait for the edge.
    task automatic drive_cycle();
        exp_t          e;
        logic [AW-1:0] a;
        e.rdy = m_run;
        e.rd  = '0;
        e.rp  = '0;
        for (int i = 0; i < NR; i++) begin
            a = read_addr[i*AW +: AW];
            if (a == PC) begin
                e.rd[i*DW +: DW] = pc_value;
            end else if (m_run) begin
                e.rp[i] = m_pend[a];
                if (write_enable_b && write_addr_b == a)      e.rd[i*DW +: DW] = write_data_b;
                else if (write_enable_a && write_addr_a == a) e.rd[i*DW +: DW] = write_data_a;
                else                                          e.rd[i*DW +: DW] = m_mem[a];
            end
        end
        q.push_back(e);
        if (reset) begin
            model_reset();
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == NREG) m_run = 1'b1;
        end else begin
            if (write_enable_a && write_addr_a != PC) m_mem[write_addr_a] = write_data_a;
            if (write_enable_b && write_addr_b != PC) begin
                m_mem[write_addr_b]  = write_data_b;
                m_pend[write_addr_b] = 1'b0;
            end
            if (pend_set && pend_addr != PC) m_pend[pend_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the queued expectation for each cycle against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (ready !== e.rdy) begin
                    fails++;
                    $display("FAIL ready t=%0t got %b want %b", $time, ready, e.rdy);
                end
                for (int i = 0; i < NR; i++) begin
                    tests++;
                    if (read_data[i*DW +: DW] !== e.rd[i*DW +: DW]) begin
                        fails++;
                        $display("FAIL read_data[%0d] t=%0t addr %0d got %h want %h", i, $time,
                                 read_addr[i*AW +: AW], read_data[i*DW +: DW], e.rd[i*DW +: DW]);
                    end
                    tests++;
                    if (read_pending[i] !== e.rp[i]) begin
                        fails++;
                        $display("FAIL read_pending[%0d] t=%0t addr %0d got %b want %b", i, $time,
                                 read_addr[i*AW +: AW], read_pending[i], e.rp[i]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        write_addr_a = '0; write_addr_b = '0; pend_addr = '0;
        write_data_a = '0; write_data_b = '0;
        pc_value = 32'h0000_0108;
        rd(4'd0, 4'd1, 4'd2);
        // The first reset edge brings the DUT out of an unknown state; nothing is checked before it.
        @(posedge clk);
        #1;
        model_reset();

        // 1: clear sequence; any write attempts are ignored while clearing.
        reset = 1'b0;
        for (int c = 0; c < 18; c++) begin
            read_addr      = NR*AW'($urandom);
            write_enable_a = 1'b1; write_addr_a = AW'(c); write_data_a = $urandom;
            pend_set       = 1'b1; pend_addr    = AW'(c);
            drive_cycle();
        end
        idle();

        // 2: port A write with same-cycle bypass, then read back from storage.
        rd(4'd3, 4'd3, 4'd0);
        write_enable_a = 1'b1; write_addr_a = 4'd3; write_data_a = 32'hDEAD_BEEF;
        drive_cycle();
        idle(); drive_cycle();

        // 3: A and B collide on r5; B wins.
        rd(4'd5, 4'd3, 4'd5);
        write_enable_a = 1'b1; write_addr_a = 4'd5; write_data_a = 32'h1111_1111;
        write_enable_b = 1'b1; write_addr_b = 4'd5; write_data_b = 32'h2222_2222;
        drive_cycle();
        idle(); drive_cycle();

        // 4: PC slot reads pc_value; writes and pend_set to it are dropped.
        pc_value = 32'h0000_0108;
        rd(4'd15, 4'd15, 4'd15);
        write_enable_a = 1'b1; write_addr_a = 4'd15; write_data_a = 32'hCAFE_0001;
        write_enable_b = 1'b1; write_addr_b = 4'd15; write_data_b = 32'hCAFE_0002;
        pend_set = 1'b1; pend_addr = 4'd15;
        drive_cycle();
        idle(); drive_cycle();

        // 5: pending scoreboard on r7.
        rd(4'd7, 4'd7, 4'd15);
        pend_set = 1'b1; pend_addr = 4'd7; drive_cycle();
        idle(); drive_cycle();
        write_enable_b = 1'b1; write_addr_b = 4'd7; write_data_b = 32'h7777_0001;
        pend_set = 1'b1; pend_addr = 4'd7; drive_cycle();
        idle(); drive_cycle();
        write_enable_b = 1'b1; write_addr_b = 4'd7; write_data_b = 32'h7777_0002; drive_cycle();
        idle(); drive_cycle();
        pend_set = 1'b1; pend_addr = 4'd7; drive_cycle();
        idle();
        write_enable_a = 1'b1; write_addr_a = 4'd7; write_data_a = 32'h7777_0003; drive_cycle();
        idle(); drive_cycle();

        // 6: reset reasserted mid-clear restarts the sequence from index 0.
        rd(4'd2, 4'd7, 4'd3);
        write_enable_a = 1'b1; write_addr_a = 4'd2; write_data_a = 32'hA5A5_A5A5;
        drive_cycle();
        idle();
        reset = 1'b1; drive_cycle();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) drive_cycle();
        reset = 1'b1; drive_cycle();
        reset = 1'b0;
        for (int c = 0; c < 18; c++) drive_cycle();

        // Random traffic, with occasional resets.
        for (int c = 0; c < 800; c++) begin
            read_addr      = NR*AW'($urandom);
            write_enable_a = 1'($urandom_range(0, 1));
            write_addr_a   = AW'($urandom);
            write_data_a   = $urandom;
            write_enable_b = 1'($urandom_range(0, 1));
            write_addr_b   = ($urandom_range(0, 3) == 0) ? write_addr_a : AW'($urandom);
            write_data_b   = $urandom;
            pend_set       = ($urandom_range(0, 2) == 0);
            pend_addr      = ($urandom_range(0, 3) == 0) ? write_addr_b : AW'($urandom);
            pc_value       = $urandom;
            reset          = ($urandom_range(0, 199) == 0);
            drive_cycle();
        end
        reset = 1'b0;
        idle();

        // Let the monitor drain the last expectation, within a bounded wait.
        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
